sram_arbiter: RTL

Two-port arbiter and sequencer in front of the SDRAM-backed static RAM controller. It converts level-held requests from a priority port A (CPU) and a secondary port B (video/DMA fetch) into the controller's edge-triggered rd/we strobes. It tracks the controller's ready handshake, including the same-word read hit that completes without ready dropping, and returns one-cycle acknowledges with registered read data. A per-request watchdog guarantees forward progress.

---
 rtl/sram_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer: turns level requests from A (priority) and B
// into edge-triggered rd/we strobes for the SRAM controller, with a watchdog.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int unsigned A_BURST_MAX = 4,
  parameter int unsigned TIMEOUT     = 64,
  localparam int unsigned ADDR_W     = 25,
  localparam int unsigned DATA_W     = 16,
  localparam int unsigned MASK_W     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  input  logic [MASK_W-1:0] a_wtbt,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  input  logic [MASK_W-1:0] b_wtbt,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [MASK_W-1:0] mem_wtbt,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned WD_W     = 10;

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, BUSY, RECOVER} state_t;

  state_t              state, state_nx;
  logic [STREAK_W-1:0] a_streak, a_streak_nx;
  logic [WD_W-1:0]     wd, wd_nx;
  logic                gnt_b, gnt_b_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic [DATA_W-1:0]   mem_din_nx, a_dout_nx, b_dout_nx;
  logic [MASK_W-1:0]   mem_wtbt_nx;
  logic                mem_rd_nx, mem_we_nx, a_ack_nx, b_ack_nx, timeout_nx, busy_nx;
  logic                pick_b, finish, expired;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state, grant decision, completion and watchdog
  always_comb begin
    state_nx    = state;
    a_streak_nx = a_streak;
    wd_nx       = wd;
    gnt_b_nx    = gnt_b;
    mem_addr_nx = mem_addr;
    mem_din_nx  = mem_din;
    mem_wtbt_nx = mem_wtbt;
    mem_rd_nx   = mem_rd;
    mem_we_nx   = mem_we;
    a_dout_nx   = a_dout;
    b_dout_nx   = b_dout;
    a_ack_nx    = 1'b0;
    b_ack_nx    = 1'b0;
    timeout_nx  = 1'b0;
    finish      = 1'b0;
    expired     = 1'b0;
    // B wins when alone, or when A has used up its burst allowance
    pick_b      = b_req && (!a_req || (a_streak == STREAK_W'(A_BURST_MAX)));

    unique case (state)
      IDLE: begin
        if (mem_ready && (a_req || b_req)) begin
          gnt_b_nx = pick_b;
          wd_nx    = '0;
          state_nx = ISSUE;
          if (pick_b) begin
            mem_addr_nx = b_addr;
            mem_din_nx  = b_din;
            mem_wtbt_nx = b_wtbt;
            mem_we_nx   = b_we;
            mem_rd_nx   = ~b_we;
            a_streak_nx = '0;
          end else begin
            mem_addr_nx = a_addr;
            mem_din_nx  = a_din;
            mem_wtbt_nx = a_wtbt;
            mem_we_nx   = a_we;
            mem_rd_nx   = ~a_we;
            if (a_streak != STREAK_W'(A_BURST_MAX)) a_streak_nx = a_streak + STREAK_W'(1);
          end
        end
      end
      ISSUE:  state_nx = SETTLE;
      SETTLE: state_nx = BUSY;
      BUSY: begin
        if (mem_ready) begin
          finish = 1'b1;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          expired = 1'b1;
        end else begin
          wd_nx = wd + WD_W'(1);
        end
        if (finish) begin
          a_ack_nx   = ~gnt_b;
          b_ack_nx   = gnt_b;
          timeout_nx = expired;
          if (mem_rd && !expired) begin
            if (gnt_b) b_dout_nx = mem_dout;
            else       a_dout_nx = mem_dout;
          end
          mem_rd_nx = 1'b0;
          mem_we_nx = 1'b0;
          state_nx  = RECOVER;
        end
      end
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // Registered outputs and bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_streak <= '0;
      wd       <= '0;
      gnt_b    <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_wtbt <= '0;
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
      a_dout   <= '0;
      b_dout   <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      timeout  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      a_streak <= a_streak_nx;
      wd       <= wd_nx;
      gnt_b    <= gnt_b_nx;
      mem_addr <= mem_addr_nx;
      mem_din  <= mem_din_nx;
      mem_wtbt <= mem_wtbt_nx;
      mem_rd   <= mem_rd_nx;
      mem_we   <= mem_we_nx;
      a_dout   <= a_dout_nx;
      b_dout   <= b_dout_nx;
      a_ack    <= a_ack_nx;
      b_ack    <= b_ack_nx;
      timeout  <= timeout_nx;
      busy     <= busy_nx;
    end
  end

endmodule
